// File: rtl/bcd_refresh_driver_if.sv
// -----------------------------------------------------------------------------
// bcd_refresh_driver_if
//   Bundles the request/result signals between a feeder and bcd_refresh_driver.
//   Signals:
//     bin   [6:0]  binary value to convert (master -> slave)
//     start        conversion request, level-sampled (master -> slave)
//     busy         conversion in progress (slave -> master)
//     done         one-cycle pulse, A/B/ovf just updated (slave -> master)
//     A     [3:0]  tens BCD digit (slave -> master)
//     B     [3:0]  ones BCD digit (slave -> master)
//     sel          free-running digit select (slave -> master)
//     ovf          last converted value exceeded 99 (slave -> master)
//   Modports: master (requester / display side), slave (the converter).
// -----------------------------------------------------------------------------
interface bcd_refresh_driver_if;
    logic [6:0] bin;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] A;
    logic [3:0] B;
    logic       sel;
    logic       ovf;

    modport master (
        output bin, start,
        input  busy, done, A, B, sel, ovf
    );

    modport slave (
        input  bin, start,
        output busy, done, A, B, sel, ovf
    );
endinterface

// File: rtl/bcd_refresh_driver.sv
// -----------------------------------------------------------------------------
// bcd_refresh_driver
//   Converts a 7-bit binary value to two BCD digits with a sequential
//   double-dabble (one shift per clock) and drives a free-running digit-select
//   line for a two-digit seven-segment display stage. Converted digits are held
//   stable between conversions; they update only on the final shift step.
//
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous, active-high reset
//     bus (slave)   bin/start in; busy/done/A/B/sel/ovf out (all registered)
//
//   Parameters:
//     REFRESH_DIV   clk cycles per sel half-period (>= 1)
//
//   Build option:
//     BCD_OVF_SAT_EN  when defined, an overflowing value (> 99) loads A=9, B=9
//                     instead of the low two BCD digits. ovf is the same either way.
// -----------------------------------------------------------------------------
module bcd_refresh_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_refresh_driver_if.slave   bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0] LAST_STEP = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [11:0] scratch_q, scratch_d;   // {H, T, O}
    logic [2:0]  step_q, step_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        ovf_q, ovf_d;

    logic [CNT_W-1:0] refresh_q;
    logic             sel_q;

    // Double-dabble correction: a digit >= 5 would become >= 10 after the
    // doubling shift, so pre-add 3 to carry it into the next digit.
    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    logic [11:0] scratch_adj;
    logic [18:0] combined;
    logic [11:0] scratch_shift;
    logic [6:0]  shreg_shift;

    always_comb begin
        scratch_adj   = {adj3(scratch_q[11:8]), adj3(scratch_q[7:4]), adj3(scratch_q[3:0])};
        combined      = {scratch_adj, shreg_q};
        scratch_shift = combined[17:6];
        shreg_shift   = {combined[5:0], 1'b0};
    end

    // -------------------------------------------------------------------------
    // FSM state and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shreg_q   <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.bin;
                    scratch_d = '0;
                    step_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = shreg_shift;
                scratch_d = scratch_shift;
                step_d    = step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    // Results come straight from the post-shift scratch so the
                    // outputs update on the same edge as the last step.
                    ovf_d = (scratch_shift[11:8] != 4'd0);
`ifdef BCD_OVF_SAT_EN
                    if (scratch_shift[11:8] != 4'd0) begin
                        a_d = 4'd9;
                        b_d = 4'd9;
                    end else begin
                        a_d = scratch_shift[7:4];
                        b_d = scratch_shift[3:0];
                    end
`else
                    a_d = scratch_shift[7:4];
                    b_d = scratch_shift[3:0];
`endif
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Free-running refresh divider, independent of the conversion FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            sel_q     <= 1'b0;
        end else if (refresh_q == CNT_LAST) begin
            refresh_q <= '0;
            sel_q     <= ~sel_q;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.A    = a_q;
    assign bus.B    = b_q;
    assign bus.sel  = sel_q;
    assign bus.ovf  = ovf_q;

endmodule
